cck_phase_recover: RTL and testbench

Parametrised successor to the fixed CCK resampling shift register in the Denise top level. It oversamples the bus CCK on the 56 MHz fabric clock and synchronises and glitch-filters it. It measures the CCK period, locks to it, and regenerates N evenly spaced pixel-clock phase enables from a local phase counter. It keeps producing those enables for a bounded holdover when CCK is missing or disturbed, so Denise clock enables never depend on a raw, unfiltered pin.

---
 rtl/cck_phase_recover.sv | 197 +++++++++++++++++++
 tb/tb_cck_phase_recover.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cck_phase_recover.sv
// cck_phase_recover
//   Oversamples the bus CCK on the fabric clock, synchronises and glitch
//   filters it, measures its period and locks to it, then regenerates
//   NUM_PHASES evenly spaced pixel-clock phase enables from a local phase
//   counter. Enables continue for up to MISS_MAX synthetic periods when CCK
//   goes missing, so downstream clock enables never follow the raw pin.
//
// Ports
//   clk       fabric clock (56 MHz), the only clock
//   reset_n   synchronous active-low reset
//   cck_in    raw CCK pin, asynchronous to clk
//   edge_en   one-cycle phase enables; [0] marks the CCK rising edge,
//             [k] fires k*S cycles later (S = 2*HALF_PERIOD/NUM_PHASES)
//   cck_out   regenerated CCK level
//   locked    registered, high in LOCKED
//   holdover  registered, high in HOLDOVER
//   period    last measured rising-to-rising period in clk cycles
module cck_phase_recover #(
  parameter int unsigned HALF_PERIOD = 8,
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER      = 2,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned MISS_MAX    = 3,
  parameter int unsigned PW          = $clog2(2*HALF_PERIOD+TOL+2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cck_in,
  output logic [NUM_PHASES-1:0] edge_en,
  output logic                  cck_out,
  output logic                  locked,
  output logic                  holdover,
  output logic [PW-1:0]         period
);

  localparam int unsigned S  = 2*HALF_PERIOD/NUM_PHASES;
  localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int unsigned GW = $clog2(LOCK_COUNT+1);
  localparam int unsigned MW = $clog2(MISS_MAX+1);

  localparam logic [PW-1:0] PC_HALF = PW'(HALF_PERIOD);
  localparam logic [PW-1:0] PC_NOM  = PW'(2*HALF_PERIOD);
  localparam logic [PW-1:0] PC_LO   = PW'(2*HALF_PERIOD-TOL);
  localparam logic [PW-1:0] PC_HI   = PW'(2*HALF_PERIOD+TOL);
  localparam logic [PW-1:0] PC_MAX  = PW'(2*HALF_PERIOD+TOL+1);
  localparam logic [PW-1:0] PC_TOL  = PW'(TOL);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_HOLDOVER
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [PW-1:0]        pc_q, pc_d;
  logic [GW-1:0]        good_q, good_d;
  logic [MW-1:0]        miss_q, miss_d;
  logic [PW-1:0]        period_q, period_d;

  logic sync_s, rise, good_rise, ph0, pc_rst, running, keep;

  assign sync_s = sync_q[SYNC_STAGES-1];
  // Filtered level is registered, so rise comes straight from flops.
  assign rise   = filt_q & ~filt_prev_q;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_s != filt_q) begin
      if (fcnt_q == FW'(FILTER-1)) filt_d = ~filt_q;
      else                          fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    miss_d    = miss_q;
    period_d  = period_q;
    ph0       = 1'b0;
    good_rise = rise && (pc_q >= PC_LO) && (pc_q <= PC_HI);

    if (rise && (state_q != ST_UNLOCKED)) period_d = pc_q;

    // Each state tests rise before its counter timeout so a real edge
    // always beats a synthetic one landing in the same cycle.
    case (state_q)
      ST_UNLOCKED: begin
        if (rise) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (rise) begin
          if (good_rise) begin
            good_d = good_q + 1'b1;
            if (good_q == GW'(LOCK_COUNT-1)) begin
              state_d = ST_LOCKED;
              ph0     = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end else if (pc_q == PC_MAX) begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (good_rise) begin
            ph0 = 1'b1;
          end else begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end else if (pc_q == PC_HI) begin
          ph0     = 1'b1;
          miss_d  = MW'(1);
          state_d = ST_HOLDOVER;
        end
      end
      ST_HOLDOVER: begin
        if (rise) begin
          // A rise just after a synthetic phase-0 only realigns pc.
          if (pc_q <= PC_TOL) begin
            state_d = ST_LOCKED;
          end else if (good_rise) begin
            ph0     = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end else if (pc_q == PC_NOM) begin
          if (miss_q == MW'(MISS_MAX)) begin
            state_d = ST_UNLOCKED;
          end else begin
            ph0    = 1'b1;
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    pc_rst = rise | ph0;
    if (pc_rst)              pc_d = PW'(1);
    else if (pc_q != PC_MAX) pc_d = pc_q + 1'b1;
    else                     pc_d = pc_q;

    running = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
    keep    = running && ((state_d == ST_LOCKED) || (state_d == ST_HOLDOVER));

    edge_en    = '0;
    edge_en[0] = ph0;
    for (int unsigned k = 1; k < NUM_PHASES; k++) begin
      edge_en[k] = keep && !pc_rst && (pc_q == PW'(k*S));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
      pc_q        <= '0;
      state_q     <= ST_UNLOCKED;
      good_q      <= '0;
      miss_q      <= '0;
      period_q    <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], cck_in};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      pc_q        <= pc_d;
      state_q     <= state_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      period_q    <= period_d;
    end
  end

  assign locked   = (state_q == ST_LOCKED);
  assign holdover = (state_q == ST_HOLDOVER);
  assign period   = period_q;
  assign cck_out  = running && (pc_q != '0) && (pc_q <= PC_HALF);

endmodule

// File: tb/tb_cck_phase_recover.sv
module tb_cck_phase_recover;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cck_in;
  logic [3:0] edge_en;
  logic       cck_out;
  logic       locked;
  logic       holdover;
  logic [4:0] period;

  cck_phase_recover #(
    .HALF_PERIOD(8),
    .NUM_PHASES (4),
    .SYNC_STAGES(2),
    .FILTER     (2),
    .TOL        (1),
    .LOCK_COUNT (4),
    .MISS_MAX   (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cck_in  (cck_in),
    .edge_en (edge_en),
    .cck_out (cck_out),
    .locked  (locked),
    .holdover(holdover),
    .period  (period)
  );

  always #5 clk = ~clk;

  // One CCK period of stimulus plus what it must produce.
  // p: period length, h: high cycles, g: offset of a 1-cycle glitch (0 none)
  // en0/nph: edge_en[0] at this rise and how many later phases follow
  // lk/ho/per: locked, holdover, period one cycle after the rise
  // hi: cck_out high cycles within the window, ho4: holdover at rise cycle
  typedef struct {
    int p; int h; int g;
    int en0; int nph;
    int lk; int ho; int per; int hi; int ho4;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] en;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  int   base;

  function automatic vec_t mk(input int p, input int h, input int g,
                              input int en0, input int nph, input int lk,
                              input int ho, input int per, input int hi,
                              input int ho4);
    vec_t v;
    v.p = p; v.h = h; v.g = g; v.en0 = en0; v.nph = nph;
    v.lk = lk; v.ho = ho; v.per = per; v.hi = hi; v.ho4 = ho4;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] e);
    sb_t s;
    s.cyc = c;
    s.en  = e;
    sb.push_back(s);
  endtask

  // Compare enables on the falling edge, then advance one cycle.
  task automatic step();
    sb_t e;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("edge_en", int'(edge_en), int'(e.en));
    end else if (edge_en != 4'b0000) begin
      chk("spurious_edge_en", int'(edge_en), 0);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_edge_en"},  int'(edge_en),  0);
    chk({nm, "_cck_out"},  int'(cck_out),  0);
    chk({nm, "_locked"},   int'(locked),   0);
    chk({nm, "_holdover"}, int'(holdover), 0);
    chk({nm, "_period"},   int'(period),   0);
  endtask

  // Rise on cck_in in cycle b appears as edge_en[0] in cycle b+4.
  task automatic drive_rec(input vec_t v);
    int b;
    int hi_cnt;
    logic [3:0] e;
    b = cyc;
    hi_cnt = 0;
    if (v.en0 != 0) push(b + 4, 4'b0001);
    for (int k = 1; k <= v.nph; k++) begin
      e = 4'b0000;
      e[k] = 1'b1;
      push(b + 4 + 4*k, e);
    end
    for (int i = 0; i < v.p; i++) begin
      cck_in = (i < v.h) || (v.g != 0 && i == v.g);
      if (i == 4) chk("holdover_at_rise", int'(holdover), v.ho4);
      if (i == 5) begin
        chk("locked",   int'(locked),   v.lk);
        chk("holdover", int'(holdover), v.ho);
        chk("period",   int'(period),   v.per);
      end
      if (cck_out) hi_cnt++;
      step();
    end
    chk("cck_out_high_cycles", hi_cnt, v.hi);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    reset_n = 1'b0;
    cck_in  = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      cck_in = ~cck_in;
      chk_all_zero("reset");
      step();
    end
    reset_n = 1'b1;
    cck_in  = 1'b0;
    wait_to(cyc + 24);

    //              p  h  g en0 nph lk ho per hi ho4
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0,  0, 0, 0)); // enter ACQUIRE
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0)); // 5th rise locks
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    tbl.push_back(mk(17, 8, 0, 1, 3, 1, 0, 16, 8, 0)); // jitter 17/15
    tbl.push_back(mk(15, 8, 0, 1, 3, 1, 0, 17, 8, 0));
    tbl.push_back(mk(17, 8, 0, 1, 3, 1, 0, 15, 8, 0));
    tbl.push_back(mk(15, 8, 0, 1, 3, 1, 0, 17, 8, 0));
    tbl.push_back(mk(14, 8, 0, 1, 3, 1, 0, 15, 8, 0)); // short period
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 14, 0, 0)); // bad rise drops lock
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0)); // re-locked
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    tbl.push_back(mk(16, 8,12, 1, 3, 1, 0, 16, 8, 0)); // glitch while low
    tbl.push_back(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));

    base = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      base = cyc;
      drive_rec(tbl[i]);
    end

    // Loss of CCK: synthetic phase-0 at pc=17, then two more 16 apart.
    cck_in = 1'b0;
    push(base + 21, 4'b0001);
    for (int r = 0; r < 3; r++) begin
      if (r > 0) push(base + 21 + 16*r, 4'b0001);
      push(base + 25 + 16*r, 4'b0010);
      push(base + 29 + 16*r, 4'b0100);
      push(base + 33 + 16*r, 4'b1000);
    end
    wait_to(base + 21);
    chk("loss_locked_pre",    int'(locked),   1);
    chk("loss_holdover_pre",  int'(holdover), 0);
    wait_to(base + 22);
    chk("loss_holdover",      int'(holdover), 1);
    chk("loss_locked",        int'(locked),   0);
    wait_to(base + 69);
    chk("holdover_last",      int'(holdover), 1);
    wait_to(base + 70);
    chk("unlock_holdover",    int'(holdover), 0);
    chk("unlock_locked",      int'(locked),   0);
    chk("unlock_cck_out",     int'(cck_out),  0);
    wait_to(base + 100);
    chk("unlock_period",      int'(period),   16);

    // Re-acquire, then a late rise that lands right after a synthetic edge.
    drive_rec(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    drive_rec(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    drive_rec(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    drive_rec(mk(16, 8, 0, 0, 0, 0, 0, 16, 0, 0));
    drive_rec(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    drive_rec(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    base = cyc;
    drive_rec(mk(18, 8, 0, 1, 3, 1, 0, 16, 8, 0));
    push(base + 21, 4'b0001);
    drive_rec(mk(16, 8, 0, 0, 3, 1, 0,  1, 9, 1));
    base = cyc;
    drive_rec(mk(16, 8, 0, 1, 3, 1, 0, 16, 8, 0));

    // Reset in the middle of holdover.
    cck_in = 1'b0;
    push(base + 21, 4'b0001);
    push(base + 25, 4'b0010);
    wait_to(base + 26);
    chk("mid_holdover",        int'(holdover), 1);
    chk("mid_holdover_cck",    int'(cck_out),  1);
    reset_n = 1'b0;
    step();
    chk_all_zero("reset_holdover1");
    step();
    chk_all_zero("reset_holdover2");
    reset_n = 1'b1;
    wait_to(cyc + 20);

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
